// File: rtl/fetch_stage.sv
// SPARC instruction-fetch stage: PC/nPC delayed-branch sequencing, stall hold, annul squash, IF/ID register.
// Optional macro FETCH_ALIGN_CHECK_EN enables the sticky branch-target misalignment flag.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        annul,
  input  logic [31:0] imem_data,
  output logic [31:0] imem_addr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic        misalign_err
);

  logic [31:0] pc;
  logic [31:0] npc;
  logic [31:0] npc_next;

  // Target low bits are always dropped; nPC+4 wraps silently at 2^32.
  always_comb begin
    npc_next = npc + 32'd4;
    if (branch_taken) npc_next = {branch_target[31:2], 2'b00};
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc          <= RESET_PC;
      npc         <= RESET_PC + 32'd4;
      if_id_instr <= 32'd0;
      if_id_pc    <= 32'd0;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      pc          <= npc;
      npc         <= npc_next;
      if_id_pc    <= pc;
      if_id_instr <= annul ? 32'd0 : imem_data;
      if_id_valid <= ~annul;
    end
  end

  assign imem_addr = pc;

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      misalign_err <= 1'b0;
    end else if (!stall && branch_taken && (branch_target[1:0] != 2'b00)) begin
      misalign_err <= 1'b1;
    end
  end
`else
  logic unused_target_bits;
  assign unused_target_bits = ^branch_target[1:0];
  assign misalign_err       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a reference model pushes expected IF/ID snapshots into a
// queue as each edge is driven; each test pops and compares them after the edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        annul = 1'b0;
  logic [31:0] imem_data;
  logic [31:0] imem_addr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic        misalign_err;

  fetch_stage dut (
    .clk(clk), .clr(clr), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .annul(annul), .imem_data(imem_data),
    .imem_addr(imem_addr), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_valid(if_id_valid), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] addr;
    logic        err;
  } snap_t;

  snap_t q[$];
  int tests = 0;
  int fails = 0;

  logic [31:0] pc_m, npc_m, instr_m, ifpc_m;
  logic        valid_m, err_m;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h8A00_0000;
      32'h0000_0004: mem_word = 32'h86A0_E001;
      default:       mem_word = {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  assign imem_data = mem_word(imem_addr);

  function automatic snap_t observe();
    snap_t s;
    s.instr = if_id_instr; s.pc = if_id_pc; s.valid = if_id_valid;
    s.addr = imem_addr;    s.err = misalign_err;
    return s;
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.instr = instr_m; s.pc = ifpc_m; s.valid = valid_m;
    s.addr = pc_m;     s.err = err_m;
    return s;
  endfunction

  task automatic model_reset();
    pc_m = 32'd0; npc_m = 32'd4; instr_m = 32'd0; ifpc_m = 32'd0;
    valid_m = 1'b0; err_m = 1'b0;
  endtask

  // Drives one clock edge, advances the model, queues the expected post-edge snapshot.
  task automatic step(input logic s, input logic bt, input logic [31:0] tgt, input logic an);
    stall = s; branch_taken = bt; branch_target = tgt; annul = an;
    if (!s) begin
      ifpc_m  = pc_m;
      instr_m = an ? 32'd0 : mem_word(pc_m);
      valid_m = !an;
`ifdef FETCH_ALIGN_CHECK_EN
      if (bt && tgt[1:0] != 2'b00) err_m = 1'b1;
`endif
      pc_m  = npc_m;
      npc_m = bt ? {tgt[31:2], 2'b00} : npc_m + 32'd4;
    end
    q.push_back(model_snap());
    @(posedge clk);
    #1;
    stall = 1'b0; branch_taken = 1'b0; annul = 1'b0;
  endtask

  task automatic test_reset();
    snap_t got, exp;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    got = observe(); exp = model_snap(); tests++;
    if (got !== exp) begin fails++; $display("FAIL reset_initial got %h expected %h", got, exp); end
    clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 32'd0, 1'b0);
      got = observe(); exp = q.pop_front(); tests++;
      if (got !== exp) begin fails++; $display("FAIL reset_run[%0d] got %h expected %h", i, got, exp); end
    end
    tests++;
    if (imem_addr !== 32'h20) begin fails++; $display("FAIL reset_pre_pc got %h expected %h", imem_addr, 32'h20); end
    #2 clr = 1'b1;
    #1;
    model_reset();
    got = observe(); exp = model_snap(); tests++;
    if (got !== exp) begin fails++; $display("FAIL reset_async got %h expected %h", got, exp); end
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h100;
    @(posedge clk);
    #1;
    got = observe(); tests++;
    if (got !== exp) begin fails++; $display("FAIL reset_held got %h expected %h", got, exp); end
    stall = 1'b0; branch_taken = 1'b0;
    clr = 1'b0;
  endtask

  task automatic test_sequential();
    snap_t got, exp;
    step(1'b0, 1'b0, 32'd0, 1'b0);
    got = observe(); exp = q.pop_front(); tests++;
    if (got !== exp) begin fails++; $display("FAIL seq_first got %h expected %h", got, exp); end
    tests++;
    if (if_id_instr !== 32'h8A00_0000 || if_id_pc !== 32'd0 || if_id_valid !== 1'b1) begin
      fails++; $display("FAIL seq_word0 got %h/%h/%b expected 8a000000/0/1", if_id_instr, if_id_pc, if_id_valid);
    end
    step(1'b0, 1'b0, 32'd0, 1'b0);
    got = observe(); exp = q.pop_front(); tests++;
    if (got !== exp) begin fails++; $display("FAIL seq_second got %h expected %h", got, exp); end
    tests++;
    if (if_id_instr !== 32'h86A0_E001 || if_id_pc !== 32'd4 || imem_addr !== 32'd8) begin
      fails++; $display("FAIL seq_word1 got %h/%h/%h expected 86a0e001/4/8", if_id_instr, if_id_pc, imem_addr);
    end
  endtask

  task automatic test_branch_annul_stall();
    snap_t got, exp, frozen;
    step(1'b0, 1'b1, 32'h40, 1'b0);
    got = observe(); exp = q.pop_front(); tests++;
    if (got !== exp) begin fails++; $display("FAIL branch_slot got %h expected %h", got, exp); end
    tests++;
    if (imem_addr !== 32'd12) begin fails++; $display("FAIL branch_slot_addr got %h expected %h", imem_addr, 32'd12); end
    step(1'b0, 1'b0, 32'd0, 1'b1);
    got = observe(); exp = q.pop_front(); tests++;
    if (got !== exp) begin fails++; $display("FAIL annul got %h expected %h", got, exp); end
    tests++;
    if (if_id_instr !== 32'd0 || if_id_valid !== 1'b0 || if_id_pc !== 32'd12 || imem_addr !== 32'h40) begin
      fails++; $display("FAIL annul_fields got %h/%b/%h/%h expected 0/0/c/40", if_id_instr, if_id_valid, if_id_pc, imem_addr);
    end
    frozen = observe();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 32'h200, 1'b0);
      got = observe(); exp = q.pop_front(); tests++;
      if (got !== exp || got !== frozen) begin
        fails++; $display("FAIL stall[%0d] got %h expected %h", i, got, exp);
      end
    end
    step(1'b0, 1'b0, 32'd0, 1'b0);
    got = observe(); exp = q.pop_front(); tests++;
    if (got !== exp || imem_addr !== 32'h44) begin fails++; $display("FAIL after_stall got %h expected %h", got, exp); end
  endtask

  task automatic test_wrap();
    snap_t got, exp;
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    got = observe(); exp = q.pop_front(); tests++;
    if (got !== exp) begin fails++; $display("FAIL wrap_branch got %h expected %h", got, exp); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'd0, 1'b0);
      got = observe(); exp = q.pop_front(); tests++;
      if (got !== exp) begin fails++; $display("FAIL wrap[%0d] got %h expected %h", i, got, exp); end
    end
    tests++;
    if (imem_addr !== 32'd4 || if_id_pc !== 32'd0) begin
      fails++; $display("FAIL wrap_final got %h/%h expected 4/0", imem_addr, if_id_pc);
    end
  endtask

  task automatic test_misalign();
    snap_t got, exp;
    logic  err_exp;
`ifdef FETCH_ALIGN_CHECK_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif
    step(1'b0, 1'b1, 32'h43, 1'b0);
    got = observe(); exp = q.pop_front(); tests++;
    if (got !== exp) begin fails++; $display("FAIL misalign_set got %h expected %h", got, exp); end
    step(1'b0, 1'b1, 32'h80, 1'b0);
    got = observe(); exp = q.pop_front(); tests++;
    if (got !== exp || imem_addr !== 32'h40) begin fails++; $display("FAIL misalign_mask got %h expected %h", got, exp); end
    step(1'b0, 1'b0, 32'd0, 1'b0);
    got = observe(); exp = q.pop_front(); tests++;
    if (got !== exp || misalign_err !== err_exp || imem_addr !== 32'h80) begin
      fails++; $display("FAIL misalign_sticky got %h expected %h", got, exp);
    end
  endtask

  task automatic test_random();
    snap_t got, exp;
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 4) == 0));
      got = observe(); exp = q.pop_front(); tests++;
      if (got !== exp) begin fails++; $display("FAIL random[%0d] got %h expected %h", i, got, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_annul_stall();
    test_wrap();
    test_misalign();
    test_random();
    tests++;
    if (q.size() != 0) begin fails++; $display("FAIL queue_drain got %0d expected 0", q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
